// File: rtl/cube_move_sequencer.sv
// rtl/cube_move_sequencer.sv - runs the stored move program against the cube-state register file
// Optional EARLY_SOLVE_EN: compare against the ideal faces after every move and stop once solved.
module cube_move_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        solved,
    output logic        err,
    output logic [3:0]  moves,
    output logic [3:0]  rf_src0,
    output logic [3:0]  rf_src1,
    input  logic [23:0] rf_rdata0,
    input  logic [23:0] rf_rdata1,
    output logic [3:0]  rf_dst,
    output logic        rf_we,
    output logic [23:0] rf_wdata,
    output logic        mv_valid,
    input  logic        mv_ready,
    output logic [3:0]  mv_code,
    output logic [71:0] mv_state,
    input  logic        mv_done,
    input  logic [71:0] mv_result
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, FETCH, LD01, LD2, ISSUE, WAIT, WB0, WB1, WB2, CNT,
        CHK01, CHK2, CMP, DONE, ERR
    } state_t;

    state_t        state, nxt;
    logic [3:0]    idx;
    logic [3:0]    code;
    logic [71:0]   sbuf;
    logic [71:0]   rbuf;
    logic [TW-1:0] tcnt;
    logic          eq0, eq1;
`ifdef EARLY_SOLVE_EN
    logic          fin;
`endif

    logic [2:0]    nib;
    logic [4:0]    shamt;
    logic [3:0]    fetch_code;
    logic          prog_end;
    logic          all_eq;

    // Nibble k of the order word sits at [23-4k:20-4k]; index 12 shifts everything out.
    assign nib        = 3'((idx < 4'd6) ? idx : idx - 4'd6);
    assign shamt      = 5'd20 - {nib, 2'b00};
    assign fetch_code = 4'(rf_rdata0 >> shamt);
    assign prog_end   = (idx == 4'd12) || (fetch_code == 4'd0);
    assign all_eq     = eq0 && eq1 && (rf_rdata0 == rf_rdata1);

    assign busy     = (state != IDLE) && (state != DONE) && (state != ERR);
    assign mv_state = sbuf;

    always_comb begin
        nxt      = state;
        rf_src0  = '0;
        rf_src1  = '0;
        rf_dst   = '0;
        rf_we    = 1'b0;
        rf_wdata = '0;
        mv_valid = 1'b0;
        mv_code  = '0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) nxt = FETCH;
            FETCH: begin
                rf_src0 = (idx < 4'd6) ? 4'd6 : 4'd7;
                nxt     = prog_end ? CHK01 : LD01;
            end
            LD01: begin
                rf_src0 = 4'd0;
                rf_src1 = 4'd1;
                nxt     = LD2;
            end
            LD2: begin
                rf_src0 = 4'd2;
                nxt     = ISSUE;
            end
            ISSUE: begin
                mv_valid = 1'b1;
                mv_code  = code;
                if (mv_ready) nxt = WAIT;
            end
            WAIT: begin
                if (mv_done)                    nxt = WB0;
                else if (tcnt + TW'(1) == TLIM) nxt = ERR;
            end
            WB0: begin
                rf_we    = 1'b1;
                rf_dst   = 4'd0;
                rf_wdata = rbuf[71:48];
                nxt      = WB1;
            end
            WB1: begin
                rf_we    = 1'b1;
                rf_dst   = 4'd1;
                rf_wdata = rbuf[47:24];
                nxt      = WB2;
            end
            WB2: begin
                rf_we    = 1'b1;
                rf_dst   = 4'd2;
                rf_wdata = rbuf[23:0];
                nxt      = CNT;
            end
            CNT: begin
                rf_we    = 1'b1;
                rf_dst   = 4'd8;
                rf_wdata = {20'b0, moves + 4'd1};
`ifdef EARLY_SOLVE_EN
                nxt      = CHK01;
`else
                nxt      = FETCH;
`endif
            end
            CHK01: begin
                rf_src0 = 4'd0;
                rf_src1 = 4'd9;
                nxt     = CHK2;
            end
            CHK2: begin
                rf_src0 = 4'd1;
                rf_src1 = 4'd10;
                nxt     = CMP;
            end
            CMP: begin
                rf_src0 = 4'd2;
                rf_src1 = 4'd11;
`ifdef EARLY_SOLVE_EN
                nxt     = (fin || all_eq) ? DONE : FETCH;
`else
                nxt     = DONE;
`endif
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            ERR: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            code   <= '0;
            sbuf   <= '0;
            rbuf   <= '0;
            tcnt   <= '0;
            eq0    <= 1'b0;
            eq1    <= 1'b0;
            moves  <= '0;
            solved <= 1'b0;
            err    <= 1'b0;
`ifdef EARLY_SOLVE_EN
            fin    <= 1'b0;
`endif
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (start) begin
                    idx    <= '0;
                    moves  <= '0;
                    solved <= 1'b0;
                    err    <= 1'b0;
`ifdef EARLY_SOLVE_EN
                    fin    <= 1'b0;
`endif
                end
                FETCH: begin
                    code <= fetch_code;
`ifdef EARLY_SOLVE_EN
                    if (prog_end) fin <= 1'b1;
`endif
                end
                LD01: begin
                    sbuf[71:48] <= rf_rdata0;
                    sbuf[47:24] <= rf_rdata1;
                end
                LD2:   sbuf[23:0] <= rf_rdata0;
                ISSUE: tcnt <= '0;
                WAIT: begin
                    if (mv_done) begin
                        rbuf <= mv_result;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (tcnt + TW'(1) == TLIM) err <= 1'b1;
                    end
                end
                CNT: begin
                    moves <= moves + 4'd1;
                    idx   <= idx + 4'd1;
                end
                CHK01: eq0 <= (rf_rdata0 == rf_rdata1);
                CHK2:  eq1 <= (rf_rdata0 == rf_rdata1);
                CMP:   if (nxt == DONE) solved <= all_eq;
                ERR:   solved <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
